video_frame_sequencer: RTL and testbench
========================================

Name: video_frame_sequencer

Overview:
- Frame-level controller for video_signal_generate. Drives the generator's enable and runs single, N-frame or continuous capture sequences.
- Turns the raw VSYNC/HSYNC stream into a pixel-valid strobe, linear pixel address and x/y coordinates for the image-memory read and dump path.
- Checks frame geometry against the configured active size and reports per-frame start/done events.

Parameters:
- H_ACT, 2448, active pixels per line
- V_ACT, 2048, active lines per frame
- ADDR_W, 23, pixel address width; must satisfy 2^ADDR_W > H_ACT*V_ACT
- FCNT_W, 8, width of the frame-count config and the frame-count status
- TIMEOUT, 1000000, ARM watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a sequence
- stop  in  1  one-cycle pulse; ends a sequence
- continuous  in  1  1 = run until stop; 0 = run num_frames frames
- num_frames  in  FCNT_W  frame count for non-continuous runs; latched on an accepted start
- VSYNC  in  1  from video_signal_generate; high for the whole frame
- HSYNC  in  1  from video_signal_generate; high during active pixels of a line
- gen_enable  out  1  enable to video_signal_generate
- busy  out  1  high whenever state is not IDLE
- pix_valid  out  1  one active pixel this cycle
- pix_addr  out  ADDR_W  linear address y*H_ACT+x of that pixel
- pix_x  out  12  column of that pixel
- pix_y  out  12  row of that pixel
- frame_start  out  1  one-cycle pulse on the first VSYNC rise of each frame
- frame_done  out  1  one-cycle pulse when a frame closes
- frames_done  out  FCNT_W  frames completed since the last accepted start; wraps
- err_geom  out  1  sticky geometry error; cleared by an accepted start
- err_timeout  out  1  sticky watchdog error; cleared by an accepted start

Behaviour:
- Reset: every output is 0; state = IDLE; internal vs_d, hs_d, counters, latched config and stop_pend are all 0.
- Edge detection: vs_d and hs_d register VSYNC and HSYNC every cycle.
  - vs_rise = VSYNC & ~vs_d; vs_fall = ~VSYNC & vs_d; hs_fall = ~HSYNC & hs_d.
- IDLE (gen_enable=0):
  - start accepted only when stop=0 and (continuous=1 or num_frames!=0). Otherwise start is ignored.
  - On accept: latch continuous and num_frames, clear frames_done and both error flags, go to ARM.
- ARM (gen_enable=1):
  - On vs_rise: clear x, y, addr and the line counter; pulse frame_start next cycle; go to ACTIVE.
  - stop in ARM: go to IDLE next cycle; no frame_done.
- ACTIVE (gen_enable=1):
  - Each cycle with VSYNC&HSYNC: the next cycle has pix_valid=1 and pix_addr/pix_x/pix_y equal to the pre-increment counters. Latency is 1 clk from the sync inputs.
  - After a pixel: x increments; addr increments.
  - Pixel arriving with x==H_ACT or addr==H_ACT*V_ACT: suppressed (pix_valid=0, counters hold), err_geom set.
  - On hs_fall: if x!=H_ACT set err_geom; then x=0, y increments (saturating at 4095), line counter increments.
  - stop in ACTIVE sets stop_pend. The frame still completes.
  - On vs_fall: go to FRAME_END.
- FRAME_END (1 cycle, gen_enable=1):
  - If line counter!=V_ACT or addr!=H_ACT*V_ACT, set err_geom.
  - Pulse frame_done and increment frames_done.
  - Go to IDLE if stop_pend, or if not continuous and the new frames_done == num_frames. Otherwise go to ARM.
  - stop_pend clears on entry to IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - stop arriving in the same cycle as vs_fall is honoured, i.e. the sequence ends after this frame.
  - A frame whose VSYNC is already high when ARM is entered is skipped; only a true vs_rise arms capture.
- rst mid-frame: immediate return to reset values; gen_enable drops asynchronously.
- pix_valid and all pulses are 0 outside ACTIVE/FRAME_END.

Optional Feature:
- Macro: VIDEO_FRAME_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ARM and clears on entering ARM.
  - When it reaches TIMEOUT with no vs_rise: set err_timeout, go to IDLE (gen_enable=0), no frame_done.
- Not defined: err_timeout is tied 0; ARM waits indefinitely; no counter is synthesized.

Test Plan (sim with H_ACT=8, V_ACT=4):
- Single frame: continuous=0, num_frames=1, start; generator produces 4 lines of 8 pixels -> 32 pix_valid with pix_addr 0..31 and (x,y) from (0,0) to (7,3); one frame_start and one frame_done; frames_done=1; gen_enable=0 and busy=0 afterwards; err_geom=0.
- Multi-frame: num_frames=3 -> 3 frame_done pulses, pix_addr restarts at 0 each frame, frames_done=3, then IDLE.
- Continuous with stop: continuous=1; stop pulsed mid-frame 2 -> frame 2 completes with all 32 pixels, frames_done=2, then IDLE; no frame_start for frame 3.
- Geometry error: one line carries 9 pixels -> 9th pixel suppressed, err_geom=1 and stays 1; next accepted start clears it.
- Start ignored:
  - num_frames=0 with continuous=0 -> busy stays 0.
  - start and stop in the same cycle -> stays IDLE.
  - start while ACTIVE -> no effect.
- Timeout (macro defined, TIMEOUT=50): start with VSYNC held 0 -> after 50 cycles err_timeout=1, gen_enable=0, busy=0. Async rst asserted mid-frame -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/video_frame_sequencer.sv
// Frame-level sequencer for video_signal_generate: arms capture, turns VSYNC/HSYNC into pixel strobes/coordinates, checks geometry.
// Optional ARM watchdog enabled by defining VIDEO_FRAME_SEQUENCER_TIMEOUT_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | generator disabled, waiting for an accepted start
// S_ARM       | generator enabled, waiting for a true VSYNC rise
// S_ACTIVE    | inside a frame, emitting pixel strobes and tracking geometry
// S_FRAME_END | one-cycle frame close: geometry check, decide ARM or IDLE
module video_frame_sequencer #(
    parameter int H_ACT   = 2448,
    parameter int V_ACT   = 2048,
    parameter int ADDR_W  = 23,
    parameter int FCNT_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [FCNT_W-1:0] num_frames,
    input  logic              VSYNC,
    input  logic              HSYNC,
    output logic              gen_enable,
    output logic              busy,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [11:0]       pix_x,
    output logic [11:0]       pix_y,
    output logic              frame_start,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frames_done,
    output logic              err_geom,
    output logic              err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACTIVE, S_FRAME_END} state_t;

    localparam logic [11:0]       H_LIM     = 12'(H_ACT);
    localparam logic [11:0]       V_LIM     = 12'(V_ACT);
    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_ACT * V_ACT);

    generate
        if ((64'd1 << ADDR_W) <= 64'(H_ACT) * 64'(V_ACT) || TIMEOUT < 1) begin : g_bad_cfg
            $error("video_frame_sequencer: ADDR_W too small or TIMEOUT < 1");
        end
    endgenerate

    state_t              state_q, state_d;
    logic                vs_d_q, hs_d_q;
    logic [11:0]         x_q, x_d, y_q, y_d, line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cont_q, cont_d;
    logic [FCNT_W-1:0]   nfr_q, nfr_d;
    logic                stop_pend_q, stop_pend_d;
    logic                pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [11:0]         pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_done_q, frame_done_d;
    logic [FCNT_W-1:0]   frames_done_q, frames_done_d;
    logic                err_geom_q, err_geom_d;
    logic                vs_rise, vs_fall, hs_fall;

    assign vs_rise = VSYNC & ~vs_d_q;
    assign vs_fall = ~VSYNC & vs_d_q;
    assign hs_fall = ~HSYNC & hs_d_q;

`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
    localparam int            TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_timeout_q, err_timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        line_d        = line_q;
        addr_d        = addr_q;
        cont_d        = cont_q;
        nfr_d         = nfr_q;
        stop_pend_d   = stop_pend_q;
        pix_valid_d   = 1'b0;
        pix_addr_d    = pix_addr_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frames_done_d = frames_done_q;
        err_geom_d    = err_geom_q;
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
        err_timeout_d = err_timeout_q;
        // Down-counter reloads outside ARM, so every ARM entry starts a fresh window.
        tmo_d         = (state_q == S_ARM) ? tmo_q - TMO_W'(1) : TMO_LOAD;
`endif

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop && (continuous || num_frames != '0)) begin
                    cont_d        = continuous;
                    nfr_d         = num_frames;
                    frames_done_d = '0;
                    err_geom_d    = 1'b0;
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
                    err_timeout_d = 1'b0;
`endif
                    state_d       = S_ARM;
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (vs_rise) begin
                    x_d           = '0;
                    y_d           = '0;
                    addr_d        = '0;
                    line_d        = '0;
                    frame_start_d = 1'b1;
                    state_d       = S_ACTIVE;
                end
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
`endif
            end
            S_ACTIVE: begin
                if (stop) stop_pend_d = 1'b1;
                if (VSYNC && HSYNC) begin
                    // Overlong line or overfull frame: drop the pixel, keep counters.
                    if (x_q == H_LIM || addr_q == FRAME_PIX) begin
                        err_geom_d = 1'b1;
                    end else begin
                        pix_valid_d = 1'b1;
                        pix_addr_d  = addr_q;
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        x_d         = x_q + 12'd1;
                        addr_d      = addr_q + ADDR_W'(1);
                    end
                end
                if (hs_fall) begin
                    if (x_q != H_LIM) err_geom_d = 1'b1;
                    x_d    = '0;
                    y_d    = (y_q == 12'hFFF) ? y_q : y_q + 12'd1;
                    line_d = line_q + 12'd1;
                end
                if (vs_fall) begin
                    frame_done_d  = 1'b1;
                    frames_done_d = frames_done_q + FCNT_W'(1);
                    state_d       = S_FRAME_END;
                end
            end
            S_FRAME_END: begin
                if (line_q != V_LIM || addr_q != FRAME_PIX) err_geom_d = 1'b1;
                if (stop_pend_q || stop || (!cont_q && frames_done_q == nfr_q)) begin
                    stop_pend_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vs_d_q        <= 1'b0;
            hs_d_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_q        <= '0;
            addr_q        <= '0;
            cont_q        <= 1'b0;
            nfr_q         <= '0;
            stop_pend_q   <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_addr_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frames_done_q <= '0;
            err_geom_q    <= 1'b0;
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
            tmo_q         <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            vs_d_q        <= VSYNC;
            hs_d_q        <= HSYNC;
            x_q           <= x_d;
            y_q           <= y_d;
            line_q        <= line_d;
            addr_q        <= addr_d;
            cont_q        <= cont_d;
            nfr_q         <= nfr_d;
            stop_pend_q   <= stop_pend_d;
            pix_valid_q   <= pix_valid_d;
            pix_addr_q    <= pix_addr_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frames_done_q <= frames_done_d;
            err_geom_q    <= err_geom_d;
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
            tmo_q         <= tmo_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    // Decoded straight from the state flop so reset drops the enable without waiting for a clock.
    assign gen_enable  = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign pix_valid   = pix_valid_q;
    assign pix_addr    = pix_addr_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frames_done = frames_done_q;
    assign err_geom    = err_geom_q;
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Scoreboard bench for video_frame_sequencer on an 8x4 frame; pixels are predicted as they are driven.
module tb_video_frame_sequencer;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int AW  = 6;
    localparam int FW  = 8;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic [FW-1:0] num_frames = '0;
    logic          VSYNC = 1'b0;
    logic          HSYNC = 1'b0;
    logic          gen_enable, busy, pix_valid, frame_start, frame_done, err_geom, err_timeout;
    logic [AW-1:0] pix_addr;
    logic [11:0]   pix_x, pix_y;
    logic [FW-1:0] frames_done;

    int n_checks = 0;
    int n_errors = 0;
    int fs_cnt = 0;
    int fd_cnt = 0;
    int pix_cnt = 0;
    int bx, by, baddr;
    logic [31:0] exp_q[$];

    video_frame_sequencer #(
        .H_ACT(H), .V_ACT(V), .ADDR_W(AW), .FCNT_W(FW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .num_frames(num_frames), .VSYNC(VSYNC), .HSYNC(HSYNC), .gen_enable(gen_enable),
        .busy(busy), .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .frame_done(frame_done), .frames_done(frames_done),
        .err_geom(err_geom), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start) fs_cnt++;
            if (frame_done) fd_cnt++;
            if (pix_valid) begin
                pix_cnt++;
                if (exp_q.size() == 0)
                    check("pix_unexpected", {2'b00, pix_addr, pix_x, pix_y}, 32'hFFFF_FFFF);
                else
                    check("pix", {2'b00, pix_addr, pix_x, pix_y}, exp_q.pop_front());
            end
        end
    end

    task automatic push_pix();
        logic [31:0] e;
        if (bx < H && baddr < H * V) begin
            e = {2'b00, AW'(baddr), 12'(bx), 12'(by)};
            exp_q.push_back(e);
            bx++;
            baddr++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic cont, input logic [FW-1:0] nf);
        continuous = cont;
        num_frames = nf;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // One generator frame; long_line gets an extra pixel, stop_line/start_line get a pulse mid-line.
    task automatic gen_frame(input bit capture, input int long_line, input int stop_line, input int start_line);
        int np;
        if (capture) begin
            bx = 0; by = 0; baddr = 0;
        end
        VSYNC = 1'b1;
        tick(2);
        for (int l = 0; l < V; l++) begin
            np = (l == long_line) ? H + 1 : H;
            for (int p = 0; p < np; p++) begin
                HSYNC = 1'b1;
                stop  = (l == stop_line && p == 2);
                start = (l == start_line && p == 2);
                if (capture) push_pix();
                tick(1);
            end
            HSYNC = 1'b0;
            stop  = 1'b0;
            start = 1'b0;
            if (capture) begin
                bx = 0;
                by++;
            end
            tick(3);
        end
        VSYNC = 1'b0;
        tick(4);
    endtask

    task automatic clear_counts();
        fs_cnt = 0; fd_cnt = 0; pix_cnt = 0;
    endtask

    function automatic logic [31:0] ctrl_vec();
        return {11'd0, gen_enable, busy, pix_valid, frame_start, frame_done, err_geom, err_timeout,
                frames_done, pix_addr};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("reset_ctrl", ctrl_vec(), 32'd0);
        check("reset_xy", {8'd0, pix_x, pix_y}, 32'd0);
        rst = 1'b0;
        tick(2);

        // single frame
        clear_counts();
        pulse_start(1'b0, 8'd1);
        check("single_busy_arm", busy, 1);
        gen_frame(1'b1, -1, -1, -1);
        check("single_pix_cnt", pix_cnt, 32);
        check("single_fs", fs_cnt, 1);
        check("single_fd", fd_cnt, 1);
        check("single_frames_done", frames_done, 1);
        check("single_idle", {gen_enable, busy}, 0);
        check("single_err_geom", err_geom, 0);
        check("single_q_empty", exp_q.size(), 0);

        // three frames
        clear_counts();
        pulse_start(1'b0, 8'd3);
        for (int f = 0; f < 3; f++) gen_frame(1'b1, -1, -1, -1);
        check("multi_pix_cnt", pix_cnt, 96);
        check("multi_fd", fd_cnt, 3);
        check("multi_frames_done", frames_done, 3);
        check("multi_busy", busy, 0);

        // continuous, stop during frame 2; frame 3 must not be captured
        clear_counts();
        pulse_start(1'b1, 8'd0);
        gen_frame(1'b1, -1, -1, -1);
        gen_frame(1'b1, -1, 1, -1);
        gen_frame(1'b0, -1, -1, -1);
        check("cont_pix_cnt", pix_cnt, 64);
        check("cont_fs", fs_cnt, 2);
        check("cont_fd", fd_cnt, 2);
        check("cont_frames_done", frames_done, 2);
        check("cont_busy", busy, 0);

        // overlong line
        clear_counts();
        pulse_start(1'b0, 8'd1);
        gen_frame(1'b1, 1, -1, -1);
        check("geom_pix_cnt", pix_cnt, 32);
        check("geom_err", err_geom, 1);
        tick(5);
        check("geom_err_sticky", err_geom, 1);
        pulse_start(1'b0, 8'd1);
        check("geom_err_cleared", err_geom, 0);
        gen_frame(1'b1, -1, -1, -1);
        check("geom_err_clean_frame", err_geom, 0);

        // ignored starts
        pulse_start(1'b0, 8'd0);
        check("ign_nf0_busy", busy, 0);
        continuous = 1'b1;
        start = 1'b1;
        stop = 1'b1;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        check("ign_start_stop_busy", busy, 0);
        clear_counts();
        pulse_start(1'b0, 8'd1);
        continuous = 1'b1;
        num_frames = 8'd5;
        gen_frame(1'b1, -1, -1, 1);
        check("ign_active_fd", fd_cnt, 1);
        check("ign_active_frames_done", frames_done, 1);
        check("ign_active_busy", busy, 0);

        // ARM with no VSYNC
        pulse_start(1'b0, 8'd1);
        tick(30);
        check("arm_wait_busy", busy, 1);
        tick(30);
`ifdef VIDEO_FRAME_SEQUENCER_TIMEOUT_EN
        check("tmo_err", err_timeout, 1);
        check("tmo_idle", {gen_enable, busy}, 0);
        check("tmo_fd_none", frame_done, 0);
`else
        check("notmo_err", err_timeout, 0);
        check("notmo_busy", {gen_enable, busy}, 2'b11);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        check("notmo_stop_idle", busy, 0);
`endif

        // async reset mid-frame
        pulse_start(1'b0, 8'd1);
        bx = 0; by = 0; baddr = 0;
        VSYNC = 1'b1;
        tick(2);
        for (int p = 0; p < 4; p++) begin
            HSYNC = 1'b1;
            push_pix();
            tick(1);
        end
        check("rst_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", ctrl_vec(), 32'd0);
        check("rst_async_xy", {8'd0, pix_x, pix_y}, 32'd0);
        tick(1);
        exp_q.delete();
        HSYNC = 1'b0;
        VSYNC = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("rst_after_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
